tanh_lut_ctrl: RTL
==================

Name: tanh_lut_ctrl

Overview:
- UART-side controller for the 256-entry tanh activation LUT. Sequences LUT initialisation from a byte stream: command, 256 data bytes, checksum.
- Sequences a full-table readback through the LUT debug port to the UART transmitter.
- Gates loading against inference and exports a lut_valid qualifier that the inference datapath must see before using the LUT.

Parameters:
- CMD_LOAD, 8'hA5, command byte that starts a table load.
- CMD_DUMP, 8'h5A, command byte that starts a table readback.
- TIMEOUT_CYCLES, 1000000, idle clocks between received bytes before an in-progress load aborts (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- infer_active  in  1  inference running; a load command is rejected while high.
- wr_addr  out  8  LUT write address.
- wr_data  out  8  LUT write data.
- wr_en  out  1  LUT write strobe, one cycle per byte.
- dbg_addr  out  8  LUT debug read address.
- dbg_data  in  8  LUT debug read data (combinational from dbg_addr).
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts when tx_valid & tx_ready.
- lut_valid  out  1  table loaded and checksum verified.
- load_err  out  1  sticky: last load failed (checksum or timeout).
- cmd_reject  out  1  one-cycle pulse: load command refused.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0, including lut_valid, load_err, wr_addr, dbg_addr and tx_data. Internal byte count, sum and timeout counter are cleared. Reset mid-load or mid-dump aborts immediately; no further wr_en or tx_valid.
- States: IDLE, LOAD, CHECK, DUMP.
- IDLE:
  - rx_valid with CMD_LOAD and !infer_active: go to LOAD. Clear count, sum and timeout. lut_valid <= 0, load_err <= 0.
  - rx_valid with CMD_LOAD and infer_active: cmd_reject pulses next cycle. State and flags are unchanged.
  - rx_valid with CMD_DUMP: go to DUMP with dbg_addr <= 0.
  - Any other byte is ignored.
- LOAD:
  - Each rx_valid byte b produces, on the next cycle, wr_en=1, wr_addr=count, wr_data=b. Then sum <= sum + b (mod 256) and count increments.
  - wr_en is low on every cycle without a preceding rx_valid. wr_addr and wr_data hold their last values.
  - After the 256th data byte (count wraps 255->0), go to CHECK.
  - infer_active changes during LOAD have no effect; lut_valid stays 0.
- CHECK:
  - The next rx_valid byte is compared with sum. Equal: lut_valid <= 1. Unequal: load_err <= 1. Both go to IDLE.
  - No LUT write occurs for the checksum byte.
- Timeout (LOAD and CHECK only):
  - The counter clears on each rx_valid and otherwise increments.
  - On reaching TIMEOUT_CYCLES: load_err <= 1, lut_valid stays 0, go to IDLE.
  - If rx_valid coincides with expiry, the byte wins: it is accepted and the counter clears.
  - Bytes already written to the LUT are not rolled back.
- DUMP:
  - Cycle after dbg_addr update: tx_data <= dbg_data, tx_valid <= 1.
  - On tx_valid & tx_ready: tx_valid <= 0. If dbg_addr == 255, go to IDLE. Otherwise dbg_addr increments and the next byte is captured the following cycle.
  - Maximum rate is one byte per 2 cycles. tx_data is stable while tx_valid is high and not yet accepted.
  - rx_valid bytes are ignored, including commands.
  - lut_valid and load_err are unchanged.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset, then CMD_LOAD followed by bytes 0x00..0xFF and checksum 0x80 -> 256 wr_en pulses with wr_addr == wr_data == 0..255, each one cycle after its rx_valid. Final lut_valid=1, load_err=0, busy=0.
- Same load with checksum 0x81 -> all 256 writes occur; lut_valid=0, load_err=1.
- CMD_LOAD then 10 bytes then silence -> after exactly TIMEOUT_CYCLES idle clocks load_err=1 and state IDLE. A subsequent valid load clears load_err and sets lut_valid.
- CMD_LOAD with infer_active=1 -> cmd_reject pulses once; no wr_en; lut_valid keeps its prior value (1 after the first test).
- CMD_DUMP with tx_ready randomly stalled -> exactly 256 tx handshakes carrying the LUT contents for addresses 0..255 in order; tx_data stable during stalls. Bytes injected on rx are ignored; busy drops after the last handshake.
- Assert rst at byte 100 of a load and at byte 50 of a dump -> all outputs 0 the same cycle; next CMD_LOAD is accepted normally.

Source files
------------

// File: rtl/tanh_lut_ctrl.sv
// tanh_lut_ctrl: UART-side controller for the 256-entry tanh activation LUT.
// Loads the table from a byte stream (command, 256 data bytes, checksum),
// streams the whole table back through the debug port on request, and
// exports lut_valid once a load has been checksum-verified.
module tanh_lut_ctrl #(
    parameter logic [7:0]  CMD_LOAD       = 8'hA5,
    parameter logic [7:0]  CMD_DUMP       = 8'h5A,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       infer_active,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic [7:0] dbg_addr,
    input  logic [7:0] dbg_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       lut_valid,
    output logic       load_err,
    output logic       cmd_reject,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DUMP  = 2'd3;

    // Timer counts idle clocks; the abort fires on the clock that would make
    // it reach TIMEOUT_CYCLES, so TMO_LAST is the last value it may hold.
    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          lut_valid_q, lut_valid_d;
    logic          load_err_q, load_err_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    dbg_addr_q, dbg_addr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          cmd_reject_q, cmd_reject_d;
    logic          busy_q, busy_d;

    // Next-state logic for the load / check / dump sequencer.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sum_d        = sum_q;
        tmo_d        = tmo_q;
        lut_valid_d  = lut_valid_q;
        load_err_d   = load_err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        dbg_addr_d   = dbg_addr_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        cmd_reject_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_LOAD) begin
                        if (infer_active) begin
                            cmd_reject_d = 1'b1;
                        end else begin
                            state_d     = S_LOAD;
                            count_d     = 8'd0;
                            sum_d       = 8'd0;
                            tmo_d       = '0;
                            lut_valid_d = 1'b0;
                            load_err_d  = 1'b0;
                        end
                    end else if (rx_data == CMD_DUMP) begin
                        state_d    = S_DUMP;
                        dbg_addr_d = 8'd0;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                // A byte arriving on the expiry clock still counts.
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    count_d   = count_q + 8'd1;
                    tmo_d     = '0;
                    if (count_q == 8'hFF) begin
                        state_d = S_CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    load_err_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        lut_valid_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    load_err_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DUMP: begin
                // Alternate capture and handshake: one byte per two clocks at best.
                if (!tx_valid_q) begin
                    tx_data_d  = dbg_data;
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (dbg_addr_q == 8'hFF) begin
                        state_d = S_IDLE;
                    end else begin
                        dbg_addr_d = dbg_addr_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= 8'd0;
            sum_q        <= 8'd0;
            tmo_q        <= '0;
            lut_valid_q  <= 1'b0;
            load_err_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            dbg_addr_q   <= 8'd0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            cmd_reject_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            lut_valid_q  <= lut_valid_d;
            load_err_q   <= load_err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            dbg_addr_q   <= dbg_addr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            cmd_reject_q <= cmd_reject_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign dbg_addr   = dbg_addr_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign lut_valid  = lut_valid_q;
    assign load_err   = load_err_q;
    assign cmd_reject = cmd_reject_q;
    assign busy       = busy_q;

endmodule
